xillybus_result_stream: RTL and testbench
=========================================

Name: xillybus_result_stream

Overview:
FPGA-side responder for the Xillybus host-read stream "read_32_result".
- Buffers 32-bit results from the face-search compute pipeline in a DEPTH-word FIFO.
- Serves them to xillybus_core through the rden/data/empty/eof/open handshake.
- Produces end-of-file once the producer has marked the last result and the buffer has drained.
- Sits between the match/compare datapath and the xillybus_core user_r_read_32_result_* ports, in the bus_clk domain.

Parameters:
DEPTH, 512, FIFO capacity in 32-bit words; power of two, minimum 4.
ADDR_W, 9, log2(DEPTH); pointer width.

Ports:
bus_clk  in  1  sole clock (Xillybus bus clock)
bus_rst_n  in  1  asynchronous active-low reset
user_r_read_32_result_rden  in  1  core read strobe; pops one word
user_r_read_32_result_data  out  32  word popped by the previous rden
user_r_read_32_result_empty  out  1  no word available
user_r_read_32_result_eof  out  1  end of stream reached
user_r_read_32_result_open  in  1  host has the device file open
res_valid  in  1  producer offers res_data
res_data  in  32  result word
res_last  in  1  qualifies res_valid: this word is the final one of the stream
res_ready  out  1  block accepts res_data this cycle
fill_level  out  ADDR_W+1  words currently stored

Behaviour:
- Reset (bus_rst_n=0, asynchronous):
  - Outputs: data=0, empty=1, eof=0, res_ready=0, fill_level=0.
  - Internal state: read/write pointers=0, last_seen=0.
- Storage and pointers:
  - Dual-pointer RAM with a count register.
  - Pointers wrap modulo DEPTH.
  - full = (count==DEPTH); empty = (count==0), driven combinationally from count.
- Push:
  - Occurs on a bus_clk edge when res_valid && res_ready.
  - res_ready = open_q && !full && !last_seen (combinational).
  - A push with res_last=1 sets last_seen. Further pushes are refused until the stream is re-opened.
- Pop:
  - Occurs on an edge when rden && !empty.
  - user_r_read_32_result_data takes mem[rd_ptr] on that same edge, giving exactly 1-cycle read latency.
  - data holds its value between pops.
  - rden while empty is ignored: no pointer, count or data change.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Push into a DEPTH-1 FIFO with a simultaneous pop: allowed. full is never exceeded.
- Pop of the word written in the same cycle cannot occur, because empty reflects the pre-edge count.
- eof:
  - Registered; set when last_seen && count==0 (evaluated after the edge's updates).
  - Held high until open falls.
  - eof is never 1 while empty is 0.
- open handling:
  - open is sampled into open_q each cycle.
  - On the falling edge (open_q=1, open=0): pointers, count, last_seen and eof clear on the next edge. data is not cleared.
  - While open_q=0: res_ready=0 and empty=1; residual writes are discarded.
  - On the rising edge of open, the stream starts fresh.
- fill_level equals count (registered), range 0..DEPTH.
- Producer side follows valid/ready semantics:
  - res_data and res_last are sampled only on accepted cycles.
  - The block never drops an accepted word.
  - The producer must hold valid until ready.
- Reset asserted mid-transfer: immediate return to reset values; any buffered data is lost.

Test Plan:
1. Reset, open=1, push 3 words 0xA0000001..3 (last on 3rd), then pulse rden 3 times → data=0xA0000001/2/3 one cycle after each rden; empty=1 after the 3rd pop; eof=1 on the cycle after count reaches 0; res_ready=0 after the last word.
2. Fill DEPTH words with no reads → res_ready=0 and fill_level=DEPTH. Push while full is held off with no change. One rden → res_ready=1 the next cycle; a simultaneous push+pop at DEPTH-1 keeps fill_level=DEPTH-1.
3. rden asserted with empty=1 for 5 cycles → data unchanged (0 after reset), fill_level=0, no pointer movement (a following push/pop returns the pushed word).
4. Continuous push and rden every cycle for 2*DEPTH words 0..2*DEPTH-1 → pointers wrap; read sequence is in order with no gaps or duplicates; fill_level stays ≤1.
5. Push 10 words with res_last on the 10th, read 4, drop open → next cycle fill_level=0, empty=1, eof=0, res_ready=0. Reopen and push 0xDEAD0000 → it is the first word read.
6. bus_rst_n pulsed low mid-stream (fill_level=7, eof=0) → outputs return to reset values asynchronously with no clock edge needed; stream resumes normally after release.

Source files
------------

// File: rtl/xillybus_result_stream.sv
// rtl/xillybus_result_stream.sv - result FIFO serving the Xillybus read_32_result host stream
// Buffers compute-pipeline results and raises eof once the final result has been read out.
module xillybus_result_stream #(
  parameter int DEPTH  = 512,
  parameter int ADDR_W = 9
) (
  input  logic              bus_clk,
  input  logic              bus_rst_n,
  input  logic              user_r_read_32_result_rden,
  output logic [31:0]       user_r_read_32_result_data,
  output logic              user_r_read_32_result_empty,
  output logic              user_r_read_32_result_eof,
  input  logic              user_r_read_32_result_open,
  input  logic              res_valid,
  input  logic [31:0]       res_data,
  input  logic              res_last,
  output logic              res_ready,
  output logic [ADDR_W:0]   fill_level
);

  localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W+1)'(DEPTH);

  logic [31:0]       mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count;
  logic [ADDR_W:0]   count_next;
  logic              open_q;
  logic              last_seen;
  logic              last_seen_next;
  logic              full;
  logic              push;
  logic              pop;
  logic              close;

  assign full       = (count == FULL_COUNT);
  // A closed device file presents as empty so the core never pops stale words.
  assign user_r_read_32_result_empty = (count == '0) || !open_q;
  assign res_ready  = open_q && !full && !last_seen;
  assign push       = res_valid && res_ready;
  assign pop        = user_r_read_32_result_rden && !user_r_read_32_result_empty;
  assign close      = open_q && !user_r_read_32_result_open;
  assign fill_level = count;

  always_comb begin
    count_next     = count;
    last_seen_next = last_seen || (push && res_last);
    case ({push, pop})
      2'b10:   count_next = count + (ADDR_W+1)'(1);
      2'b01:   count_next = count - (ADDR_W+1)'(1);
      default: count_next = count;
    endcase
  end

  always_ff @(posedge bus_clk) begin
    if (push) begin
      mem[wr_ptr] <= res_data;
    end
  end

  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) begin
      open_q                     <= 1'b0;
      wr_ptr                     <= '0;
      rd_ptr                     <= '0;
      count                      <= '0;
      last_seen                  <= 1'b0;
      user_r_read_32_result_eof  <= 1'b0;
      user_r_read_32_result_data <= '0;
    end else begin
      open_q <= user_r_read_32_result_open;
      if (close) begin
        // data is deliberately kept; the host may still inspect the last word.
        wr_ptr                    <= '0;
        rd_ptr                    <= '0;
        count                     <= '0;
        last_seen                 <= 1'b0;
        user_r_read_32_result_eof <= 1'b0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + ADDR_W'(1);
        end
        if (pop) begin
          rd_ptr                     <= rd_ptr + ADDR_W'(1);
          user_r_read_32_result_data <= mem[rd_ptr];
        end
        count     <= count_next;
        last_seen <= last_seen_next;
        if (last_seen_next && (count_next == '0)) begin
          user_r_read_32_result_eof <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_xillybus_result_stream.sv
// tb/tb_xillybus_result_stream.sv - directed self-checking bench for xillybus_result_stream
module tb_xillybus_result_stream;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic              clk;
  logic              rst_n;
  logic              rden;
  logic [31:0]       rd_data;
  logic              empty;
  logic              eof;
  logic              open;
  logic              res_valid;
  logic [31:0]       res_data;
  logic              res_last;
  logic              res_ready;
  logic [ADDR_W:0]   fill_level;

  int total;
  int bad;

  xillybus_result_stream #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .bus_clk                     (clk),
    .bus_rst_n                   (rst_n),
    .user_r_read_32_result_rden  (rden),
    .user_r_read_32_result_data  (rd_data),
    .user_r_read_32_result_empty (empty),
    .user_r_read_32_result_eof   (eof),
    .user_r_read_32_result_open  (open),
    .res_valid                   (res_valid),
    .res_data                    (res_data),
    .res_last                    (res_last),
    .res_ready                   (res_ready),
    .fill_level                  (fill_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (total=%0d bad=%0d)", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [31:0] d, input logic last);
    res_valid = 1'b1;
    res_data  = d;
    res_last  = last;
    tick();
    res_valid = 1'b0;
    res_last  = 1'b0;
  endtask

  task automatic pop_word();
    rden = 1'b1;
    tick();
    rden = 1'b0;
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    open      = 1'b0;
    rden      = 1'b0;
    res_valid = 1'b0;
    res_data  = '0;
    res_last  = 1'b0;

    // reset values
    #23;
    chk("rst_data", rd_data, 0);
    chk("rst_empty", empty, 1);
    chk("rst_eof", eof, 0);
    chk("rst_ready", res_ready, 0);
    chk("rst_fill", fill_level, 0);
    rst_n = 1'b1;
    open  = 1'b1;
    tick();
    chk("open_ready", res_ready, 1);

    // 1: three words, last on the third
    push_word(32'hA000_0001, 1'b0);
    push_word(32'hA000_0002, 1'b0);
    push_word(32'hA000_0003, 1'b1);
    chk("t1_fill3", fill_level, 3);
    chk("t1_ready_after_last", res_ready, 0);
    chk("t1_eof_pending", eof, 0);
    pop_word();
    chk("t1_data1", rd_data, 32'hA000_0001);
    pop_word();
    chk("t1_data2", rd_data, 32'hA000_0002);
    chk("t1_eof_early", eof, 0);
    pop_word();
    chk("t1_data3", rd_data, 32'hA000_0003);
    chk("t1_empty", empty, 1);
    chk("t1_eof", eof, 1);
    tick();
    chk("t1_eof_held", eof, 1);
    open = 1'b0;
    tick();
    chk("t1_close_eof", eof, 0);
    open = 1'b1;
    tick();

    // 2: fill to DEPTH, refuse while full, then pop and push+pop at DEPTH-1
    for (int i = 0; i < DEPTH; i++) push_word(32'h2000_0000 + 32'(i), 1'b0);
    chk("t2_fill_full", fill_level, DEPTH);
    chk("t2_ready_full", res_ready, 0);
    res_valid = 1'b1;
    res_data  = 32'h0000_0BAD;
    tick();
    chk("t2_full_hold", fill_level, DEPTH);
    rden = 1'b1;
    tick();
    rden = 1'b0;
    chk("t2_pop_data", rd_data, 32'h2000_0000);
    chk("t2_ready_again", res_ready, 1);
    chk("t2_fill_dm1", fill_level, DEPTH - 1);
    rden = 1'b1;
    tick();
    rden      = 1'b0;
    res_valid = 1'b0;
    chk("t2_pushpop_fill", fill_level, DEPTH - 1);
    chk("t2_pushpop_data", rd_data, 32'h2000_0001);
    rden = 1'b1;
    for (int i = 0; i < DEPTH - 1; i++) tick();
    rden = 1'b0;
    chk("t2_drain_tail", rd_data, 32'h0000_0BAD);
    chk("t2_drain_fill", fill_level, 0);
    chk("t2_no_eof", eof, 0);

    // 3: rden while empty, straight after reset
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    tick();
    rden = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    rden = 1'b0;
    chk("t3_data", rd_data, 0);
    chk("t3_fill", fill_level, 0);
    chk("t3_empty", empty, 1);
    push_word(32'h1234_5678, 1'b0);
    pop_word();
    chk("t3_first_word", rd_data, 32'h1234_5678);

    // 4: streaming push+pop every cycle across two pointer wraps
    rden      = 1'b1;
    res_valid = 1'b1;
    for (int j = 0; j < 2 * DEPTH; j++) begin
      res_data = 32'(j);
      tick();
      if (j > 0) chk($sformatf("t4_seq%0d", j), rd_data, j - 1);
      chk("t4_fill_le1", fill_level <= 1, 1);
    end
    res_valid = 1'b0;
    tick();
    rden = 1'b0;
    chk("t4_final", rd_data, 2 * DEPTH - 1);
    chk("t4_fill0", fill_level, 0);

    // 5: close mid-stream, reopen fresh
    for (int i = 0; i < 10; i++) push_word(32'h0000_0500 + 32'(i), i == 9);
    rden = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    rden = 1'b0;
    chk("t5_read4", rd_data, 32'h0000_0503);
    chk("t5_fill6", fill_level, 6);
    open = 1'b0;
    tick();
    chk("t5_fill", fill_level, 0);
    chk("t5_empty", empty, 1);
    chk("t5_eof", eof, 0);
    chk("t5_ready", res_ready, 0);
    chk("t5_data_kept", rd_data, 32'h0000_0503);
    open = 1'b1;
    tick();
    push_word(32'hDEAD_0000, 1'b0);
    pop_word();
    chk("t5_reopen_first", rd_data, 32'hDEAD_0000);

    // 6: asynchronous reset mid-stream
    for (int i = 0; i < 7; i++) push_word(32'h0000_6000 + 32'(i), 1'b0);
    chk("t6_fill7", fill_level, 7);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_fill", fill_level, 0);
    chk("t6_data", rd_data, 0);
    chk("t6_empty", empty, 1);
    chk("t6_ready", res_ready, 0);
    chk("t6_eof", eof, 0);
    #2;
    rst_n = 1'b1;
    tick();
    push_word(32'h0000_0077, 1'b1);
    pop_word();
    chk("t6_resume_data", rd_data, 32'h0000_0077);
    chk("t6_resume_eof", eof, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
